// File: rtl/core_pkg.sv
// Shared definitions for the write-back / register-file slice.
// Provides the load funct3 encodings, the write-back FSM state type and the
// default data width used by the modules that import it.
package core_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB handshake bundle between the memory stage (master) and the
// write-back stage (slave).
//   wb_valid/wb_ready     : entry handshake
//   wb_regwrite           : entry writes a register
//   wb_memtoreg           : 1 selects load data, 0 selects ALU result
//   wb_rd                 : destination register index
//   wb_alu_result         : ALU result, low 2 bits double as load byte offset
//   wb_mem_rdata          : raw aligned word from data memory
//   wb_load_type          : load funct3
interface wb_regfile_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            wb_valid;
  logic            wb_ready;
  logic            wb_regwrite;
  logic            wb_memtoreg;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_alu_result;
  logic [XLEN-1:0] wb_mem_rdata;
  logic [2:0]      wb_load_type;

  modport master (
    output wb_valid, wb_regwrite, wb_memtoreg, wb_rd,
           wb_alu_result, wb_mem_rdata, wb_load_type,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_regwrite, wb_memtoreg, wb_rd,
           wb_alu_result, wb_mem_rdata, wb_load_type,
    output wb_ready
  );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load alignment: picks the byte/halfword/word addressed by
// offset out of the raw memory word and sign- or zero-extends it to XLEN.
//   rdata     : raw aligned word from data memory
//   offset    : byte offset (low 2 bits of the effective address)
//   load_type : load funct3
//   aligned   : extended result (0 for unlisted funct3 values)
module wb_load_align
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] aligned
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    word     = rdata[31:0];
    byte_sel = word[{offset, 3'b000} +: 8];
    // Halfword loads use only offset[1]; misaligned offsets trap upstream.
    half_sel = offset[1] ? word[31:16] : word[15:0];
    aligned  = '0;
    case (load_type)
      F3_LB:   aligned = XLEN'($signed(byte_sel));
      F3_LBU:  aligned = XLEN'(byte_sel);
      F3_LH:   aligned = XLEN'($signed(half_sel));
      F3_LHU:  aligned = XLEN'(half_sel);
      F3_LW:   aligned = XLEN'($signed(word));
      F3_LD:   if (XLEN == 64) aligned = rdata;
      default: aligned = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage with integrated register file.
// Accepts MEM/WB entries over the wb interface, selects ALU result or
// aligned load data, writes the register file and exposes NUM_READ
// combinational read ports with same-cycle bypass of the value being
// written. After reset the array is scrubbed to zero one entry per cycle
// before entries are accepted. Accepted entries are counted.
//   clk          : clock, all state on rising edge
//   reset        : synchronous, active-low
//   wb           : MEM/WB handshake (slave side)
//   rs_addr      : packed read indices, port i at [i*AW +: AW]
//   rs_data      : packed read data, port i at [i*XLEN +: XLEN]
//   fwd_valid    : a nonzero register is written this cycle
//   fwd_rd       : index being written
//   fwd_data     : value being written
//   retire_count : entries accepted since reset (wraps at 2^64)
module wb_regfile
  import core_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEFAULT,
  parameter  int unsigned NREGS    = 32,
  parameter  int unsigned NUM_READ = 2,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_regfile_if.slave              wb,
  input  logic [NUM_READ*AW-1:0]   rs_addr,
  output logic [NUM_READ*XLEN-1:0] rs_data,
  output logic                     fwd_valid,
  output logic [AW-1:0]            fwd_rd,
  output logic [XLEN-1:0]          fwd_data,
  output logic [63:0]              retire_count
);

  wb_state_t       state;
  logic [AW-1:0]   scrub_idx;
  logic            ready_q;
  logic [63:0]     retire_q;
  logic [XLEN-1:0] regs [1:NREGS-1];

  logic            accept;
  logic [XLEN-1:0] load_aligned;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;

  wb_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .rdata     (wb.wb_mem_rdata),
    .offset    (wb.wb_alu_result[1:0]),
    .load_type (wb.wb_load_type),
    .aligned   (load_aligned)
  );

  // An entry presented on the same edge that reset is sampled low is
  // dropped: it neither writes the array nor counts as retired.
  assign accept       = wb.wb_valid & ready_q & reset;
  assign wdata        = wb.wb_memtoreg ? load_aligned : wb.wb_alu_result;
  assign fwd_valid    = accept & wb.wb_regwrite & (wb.wb_rd != '0);
  assign fwd_rd       = ready_q ? wb.wb_rd : '0;
  assign fwd_data     = ready_q ? wdata : '0;
  assign wb.wb_ready  = ready_q;
  assign retire_count = retire_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SCRUB;
      scrub_idx <= AW'(1);
      ready_q   <= 1'b0;
      retire_q  <= '0;
    end else begin
      case (state)
        SCRUB: begin
          scrub_idx <= scrub_idx + 1'b1;
          if (scrub_idx == AW'(NREGS - 1)) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (accept) retire_q <= retire_q + 64'd1;
        end
        default: begin
          state   <= SCRUB;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; the scrub sequence provides the zero state.
  // scrub_idx runs 1..NREGS-1, so x0 is never addressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == SCRUB) begin
        regs[scrub_idx] <= '0;
      end else if (fwd_valid) begin
        regs[wb.wb_rd] <= wdata;
      end
    end
  end

  always_comb begin
    rs_data = '0;
    rd_addr = '0;
    rd_val  = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rd_addr = rs_addr[i*AW +: AW];
      if (!ready_q || rd_addr == '0) begin
        rd_val = '0;
      end else if (fwd_valid && fwd_rd == rd_addr) begin
        rd_val = wdata;
      end else begin
        rd_val = regs[rd_addr];
      end
      rs_data[i*XLEN +: XLEN] = rd_val;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned NUM_READ = 2;
  localparam int unsigned AW       = 5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_READ*AW-1:0]   rs_addr;
  logic [NUM_READ*XLEN-1:0] rs_data;
  logic                     fwd_valid;
  logic [AW-1:0]            fwd_rd;
  logic [XLEN-1:0]          fwd_data;
  logic [63:0]              retire_count;

  always #5 clk = ~clk;

  wb_regfile_if #(.XLEN(XLEN), .AW(AW)) bus ();

  wb_regfile #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NUM_READ (NUM_READ)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (bus),
    .rs_addr      (rs_addr),
    .rs_data      (rs_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .retire_count (retire_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [XLEN-1:0]  m_regs [NREGS];
  bit               m_run = 1'b0;
  int               m_scrub_done = 0;
  longint unsigned  m_retire = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_wdata(input logic memtoreg, input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] rdata, input logic [2:0] lt);
    longint          v;
    longint unsigned w;
    longint unsigned off;
    logic [1:0]      lo;
    if (!memtoreg) return alu;
    w   = 64'(rdata[31:0]);
    lo  = alu[1:0];
    off = 64'(lo);
    case (lt)
      3'b000, 3'b100: begin
        v = longint'((w >> (8 * off)) % 256);
        if (lt == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = longint'((w >> (16 * (off / 2))) % 65536);
        if (lt == 3'b001 && v >= 32768) v = v - 65536;
      end
      3'b010: begin
        v = longint'(w);
        if (v >= (longint'(1) << 31)) v = v - (longint'(1) << 32);
      end
      3'b011:  v = (XLEN == 64) ? longint'(rdata) : 0;
      default: v = 0;
    endcase
    return v[XLEN-1:0];
  endfunction

  function automatic bit model_fwd();
    return m_run && reset && bus.wb_valid && bus.wb_regwrite && (bus.wb_rd != 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    if (!m_run || a == 0) return '0;
    if (model_fwd() && bus.wb_rd == a)
      return ref_wdata(bus.wb_memtoreg, bus.wb_alu_result, bus.wb_mem_rdata, bus.wb_load_type);
    return m_regs[a];
  endfunction

  // Apply the effect of the coming edge to the model, then advance.
  task automatic tick();
    if (!reset) begin
      m_run = 1'b0;
      m_scrub_done = 0;
      m_retire = 0;
    end else if (!m_run) begin
      m_scrub_done++;
      if (m_scrub_done == NREGS - 1) begin
        m_run = 1'b1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
      end
    end else if (bus.wb_valid) begin
      m_retire++;
      if (bus.wb_regwrite && bus.wb_rd != 0)
        m_regs[bus.wb_rd] = ref_wdata(bus.wb_memtoreg, bus.wb_alu_result,
                                      bus.wb_mem_rdata, bus.wb_load_type);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [AW-1:0] rd,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdata, input logic [2:0] lt);
    bus.wb_valid      = v;
    bus.wb_regwrite   = rw;
    bus.wb_memtoreg   = m2r;
    bus.wb_rd         = rd;
    bus.wb_alu_result = alu;
    bus.wb_mem_rdata  = rdata;
    bus.wb_load_type  = lt;
  endtask

  task automatic drive_random(input logic v);
    drive(v, 1'($urandom), 1'($urandom), AW'($urandom_range(0, NREGS - 1)),
          $urandom, $urandom, 3'($urandom_range(0, 7)));
    rs_addr = NUM_READ*AW'($urandom);
  endtask

  task automatic check_all(input string tag);
    logic [AW-1:0] a;
    bit fv;
    fv = model_fwd();
    check({tag, ".ready"}, 64'(bus.wb_ready), 64'(m_run));
    check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(fv));
    if (fv) begin
      check({tag, ".fwd_rd"}, 64'(fwd_rd), 64'(bus.wb_rd));
      check({tag, ".fwd_data"}, 64'(fwd_data),
            64'(ref_wdata(bus.wb_memtoreg, bus.wb_alu_result, bus.wb_mem_rdata, bus.wb_load_type)));
    end
    check({tag, ".retire"}, retire_count, m_retire);
    for (int p = 0; p < NUM_READ; p++) begin
      a = rs_addr[p*AW +: AW];
      check($sformatf("%s.rs%0d", tag, p), 64'(rs_data[p*XLEN +: XLEN]), 64'(exp_read(a)));
    end
  endtask

  task automatic wait_scrub(input string tag);
    int n;
    n = 0;
    while (!bus.wb_ready && n < 100) begin
      if (n == 5) begin
        check({tag, ".scrub_fwd_valid"}, 64'(fwd_valid), 64'd0);
        check({tag, ".scrub_fwd_data"}, 64'(fwd_data), 64'd0);
        check({tag, ".scrub_rs0"}, 64'(rs_data[XLEN-1:0]), 64'd0);
        check({tag, ".scrub_retire"}, retire_count, 64'd0);
      end
      tick();
      n++;
    end
    check({tag, ".scrub_cycles"}, 64'(n), 64'(NREGS - 1));
    check({tag, ".ready_model"}, 64'(bus.wb_ready), 64'(m_run));
  endtask

  logic [2:0]      lt_tab  [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
  logic [1:0]      off_tab [5] = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd2};
  logic [XLEN-1:0] exp_tab [5] = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080,
                                   32'hFFFF80F1, 32'h000080F1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned base;
    logic [AW-1:0] rd_k;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000);
    rs_addr = {AW'(3), AW'(9)};
    tick();
    tick();
    #2;
    check("rst.ready", 64'(bus.wb_ready), 64'd0);
    check("rst.fwd_valid", 64'(fwd_valid), 64'd0);
    check("rst.fwd_rd", 64'(fwd_rd), 64'd0);
    check("rst.fwd_data", 64'(fwd_data), 64'd0);
    check("rst.retire", retire_count, 64'd0);
    check("rst.rs_data", 64'(rs_data), 64'd0);

    // Release reset; valid entries during scrub must be ignored.
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, AW'(9), 32'h55AA55AA, '0, 3'b010);
    wait_scrub("scrub1");
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000);

    for (int i = 0; i < NREGS; i++) begin
      rs_addr = {AW'(NREGS - 1 - i), AW'(i)};
      #2;
      check($sformatf("zero.rs0.r%0d", i), 64'(rs_data[XLEN-1:0]), 64'd0);
      check($sformatf("zero.rs1.r%0d", NREGS - 1 - i), 64'(rs_data[2*XLEN-1:XLEN]), 64'd0);
      tick();
    end

    // ALU write with same-cycle bypass, then array read.
    drive(1'b1, 1'b1, 1'b0, AW'(5), 32'hDEADBEEF, $urandom, 3'($urandom));
    rs_addr = {AW'(5), AW'(5)};
    #2;
    check("alu.fwd_valid", 64'(fwd_valid), 64'd1);
    check("alu.fwd_rd", 64'(fwd_rd), 64'd5);
    check("alu.fwd_data", 64'(fwd_data), 64'hDEADBEEF);
    check("alu.bypass0", 64'(rs_data[XLEN-1:0]), 64'hDEADBEEF);
    check("alu.bypass1", 64'(rs_data[2*XLEN-1:XLEN]), 64'hDEADBEEF);
    tick();
    bus.wb_valid = 1'b0;
    #2;
    check("alu.array", 64'(rs_data[XLEN-1:0]), 64'hDEADBEEF);
    check("alu.retire", retire_count, 64'd1);
    tick();

    // Load alignment directed cases.
    for (int k = 0; k < 5; k++) begin
      rd_k = AW'(10 + k);
      drive(1'b1, 1'b1, 1'b1, rd_k, {30'($urandom), off_tab[k]}, 32'h80F17F22, lt_tab[k]);
      rs_addr = {AW'(0), rd_k};
      #2;
      check($sformatf("load%0d.fwd_data", k), 64'(fwd_data), 64'(exp_tab[k]));
      check($sformatf("load%0d.bypass", k), 64'(rs_data[XLEN-1:0]), 64'(exp_tab[k]));
      tick();
      bus.wb_valid = 1'b0;
      #2;
      check($sformatf("load%0d.array", k), 64'(rs_data[XLEN-1:0]), 64'(exp_tab[k]));
      tick();
    end

    // Write to x0 is dropped but still retires.
    base = m_retire;
    drive(1'b1, 1'b1, 1'b0, AW'(0), 32'h00001234, '0, 3'b000);
    rs_addr = {AW'(0), AW'(0)};
    #2;
    check("x0.fwd_valid", 64'(fwd_valid), 64'd0);
    check("x0.rs0", 64'(rs_data[XLEN-1:0]), 64'd0);
    tick();
    bus.wb_valid = 1'b0;
    #2;
    check("x0.retire", retire_count, base + 1);
    check("x0.rs0_after", 64'(rs_data[XLEN-1:0]), 64'd0);

    // Invalid entries with regwrite set change nothing.
    base = m_retire;
    drive(1'b0, 1'b1, 1'b0, AW'(5), 32'h0BADF00D, '0, 3'b000);
    rs_addr = {AW'(10), AW'(5)};
    for (int c = 0; c < 3; c++) begin
      #2;
      check($sformatf("idle%0d.fwd_valid", c), 64'(fwd_valid), 64'd0);
      check($sformatf("idle%0d.rs0", c), 64'(rs_data[XLEN-1:0]), 64'hDEADBEEF);
      tick();
    end
    #2;
    check("idle.retire", retire_count, base);

    // Ten back-to-back random entries.
    base = m_retire;
    for (int c = 0; c < 10; c++) begin
      drive_random(1'b1);
      #2;
      check_all($sformatf("b2b%0d", c));
      tick();
    end
    bus.wb_valid = 1'b0;
    #2;
    check("b2b.retire", retire_count, base + 10);

    // Random traffic against the model.
    for (int c = 0; c < 60; c++) begin
      drive_random(1'($urandom));
      #2;
      check_all($sformatf("rnd%0d", c));
      tick();
    end

    // Reset mid-RUN with a valid entry targeting x7.
    drive(1'b1, 1'b1, 1'b0, AW'(7), 32'hCAFEF00D, '0, 3'b000);
    rs_addr = {AW'(7), AW'(7)};
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, AW'(7), 32'hCAFEF00D, '0, 3'b000);
    #2;
    check("mid.retire", retire_count, 64'd0);
    check("mid.ready", 64'(bus.wb_ready), 64'd0);
    check("mid.fwd_valid", 64'(fwd_valid), 64'd0);
    wait_scrub("scrub2");
    bus.wb_valid = 1'b0;
    #2;
    check("mid.reg7", 64'(rs_data[XLEN-1:0]), 64'd0);
    check("mid.retire_after", retire_count, 64'd0);
    check_all("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
